// File: rtl/riscv_dm_pkg.sv
// Shared DMI payload types, opcodes and the arbiter FSM encoding.
package riscv_dm_pkg;

   localparam int unsigned DMI_ADDR_WIDTH = 7;
   localparam int unsigned DMI_DATA_WIDTH = 32;
   localparam int unsigned DMI_OP_WIDTH   = 2;

   // Request opcodes
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_READ  = 2'd1;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_WRITE = 2'd2;

   // Response status codes
   localparam logic [DMI_OP_WIDTH-1:0] DMI_RESP_SUCCESS = 2'd0;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_FAILED    = 2'd2;
   localparam logic [DMI_OP_WIDTH-1:0] DMI_OP_BUSY      = 2'd3;

   typedef struct packed {
      logic [DMI_ADDR_WIDTH-1:0] addr;
      logic [DMI_DATA_WIDTH-1:0] data;
      logic [DMI_OP_WIDTH-1:0]   op;
   } dmi_req_t;

   typedef struct packed {
      logic [DMI_DATA_WIDTH-1:0] data;
      logic [DMI_OP_WIDTH-1:0]   op;
   } dmi_resp_t;

   localparam dmi_req_t DMI_REQ_ZERO =
      {{DMI_ADDR_WIDTH{1'b0}}, {DMI_DATA_WIDTH{1'b0}}, {DMI_OP_WIDTH{1'b0}}};
   localparam dmi_resp_t DMI_RESP_ZERO =
      {{DMI_DATA_WIDTH{1'b0}}, {DMI_OP_WIDTH{1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 32'd1) ? $clog2(n) : 32'd1;
   endfunction

endpackage

// File: rtl/riscv_dmi_rr_arb.sv
// Combinational round-robin grant: first requester at or after ptr_i, cyclically.
module riscv_dmi_rr_arb
   import riscv_dm_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 2,
   parameter int unsigned IDX_BITS = idx_bits(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]  req_i,
   input  logic [IDX_BITS-1:0] ptr_i,
   output logic [NUM_REQ-1:0]  gnt_oh_o,
   output logic [IDX_BITS-1:0] gnt_idx_o,
   output logic                gnt_valid_o
);

   logic [IDX_BITS-1:0] idx_s;

   // Scan requesters starting at the pointer and take the first one found.
   always_comb begin
      gnt_oh_o    = {NUM_REQ{1'b0}};
      gnt_idx_o   = {IDX_BITS{1'b0}};
      gnt_valid_o = 1'b0;
      idx_s       = {IDX_BITS{1'b0}};
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx_s = IDX_BITS'((32'(ptr_i) + off) % NUM_REQ);
         if (!gnt_valid_o && req_i[idx_s]) begin
            gnt_valid_o     = 1'b1;
            gnt_oh_o[idx_s] = 1'b1;
            gnt_idx_o       = idx_s;
         end else begin
            gnt_valid_o = gnt_valid_o;
         end
      end
   end

endmodule

// File: rtl/riscv_dmi_arbiter.sv
// Multi-source DMI front end: round-robin arbitration of NUM_SRC initiators
// onto one DM channel, one transaction outstanding, response routed back to
// its owner, and a stalled DM turned into a FAILED response after a timeout.
// A timed-out transaction leaves a "stale" response pending at the DM; the
// first DM response after that is swallowed before anything new is issued.
module riscv_dmi_arbiter
   import riscv_dm_pkg::*;
#(
   parameter  int unsigned NUM_SRC        = 2,
   parameter  int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned SRC_BITS       = idx_bits(NUM_SRC)
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [NUM_SRC-1:0]  src_req_valid_i,
   output logic [NUM_SRC-1:0]  src_req_ready_o,
   input  dmi_req_t            src_req_i [NUM_SRC],
   output logic [NUM_SRC-1:0]  src_resp_valid_o,
   input  logic [NUM_SRC-1:0]  src_resp_ready_i,
   output dmi_resp_t           src_resp_o,
   output logic                dm_req_valid_o,
   input  logic                dm_req_ready_i,
   output dmi_req_t            dm_req_o,
   input  logic                dm_resp_valid_i,
   output logic                dm_resp_ready_o,
   input  dmi_resp_t           dm_resp_i,
   output logic                busy_o,
   output logic [SRC_BITS-1:0] owner_o,
   output logic                timeout_o,
   input  logic                timeout_clr_i
);

   localparam bit          TO_EN = (TIMEOUT_CYCLES != 32'd0);
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
   localparam logic [SRC_BITS-1:0] SRC_LAST = SRC_BITS'(NUM_SRC - 32'd1);

   arb_state_e          state_q, state_d;
   logic [SRC_BITS-1:0] ptr_q, ptr_d;
   logic [SRC_BITS-1:0] owner_q, owner_d;
   dmi_req_t            dm_req_q, dm_req_d;
   dmi_resp_t           src_resp_q, src_resp_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                stale_q, stale_d;
   logic                timeout_q, timeout_d;
   logic                timeout_set_s;

   logic [NUM_SRC-1:0]  gnt_oh_s;
   logic [SRC_BITS-1:0] gnt_idx_s;
   logic                gnt_valid_s;

   riscv_dmi_rr_arb #(
      .NUM_REQ  (NUM_SRC),
      .IDX_BITS (SRC_BITS)
   ) u_rr_arb (
      .req_i       (src_req_valid_i),
      .ptr_i       (ptr_q),
      .gnt_oh_o    (gnt_oh_s),
      .gnt_idx_o   (gnt_idx_s),
      .gnt_valid_o (gnt_valid_s)
   );

   // Next-state, payload capture, timeout counting and stale tracking.
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      owner_d         = owner_q;
      dm_req_d        = dm_req_q;
      src_resp_d      = src_resp_q;
      cnt_d           = cnt_q;
      stale_d         = stale_q;
      timeout_set_s   = 1'b0;
      src_req_ready_o = {NUM_SRC{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (gnt_valid_s) begin
               src_req_ready_o = gnt_oh_s;
               dm_req_d        = src_req_i[gnt_idx_s];
               owner_d         = gnt_idx_s;
               state_d         = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Nothing goes to the DM while its previous answer is still owed.
            if (!stale_q && dm_req_ready_i) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_WAIT: begin
            // A real response beats an expiry landing in the same cycle.
            if (dm_resp_valid_i) begin
               src_resp_d = dm_resp_i;
               state_d    = ST_RESP;
            end else if (TO_EN && (cnt_q == CNT_LAST)) begin
               src_resp_d    = {{DMI_DATA_WIDTH{1'b0}}, DMI_OP_FAILED};
               timeout_set_s = 1'b1;
               stale_d       = 1'b1;
               state_d       = ST_RESP;
            end else if (TO_EN) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_RESP: begin
            if (src_resp_ready_i[owner_q]) begin
               ptr_d   = (owner_q == SRC_LAST) ? {SRC_BITS{1'b0}} : (owner_q + SRC_BITS'(1));
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Stale is only ever set from WAIT, so clearing elsewhere cannot collide.
      if (stale_q && dm_resp_valid_i && (state_q != ST_WAIT)) begin
         stale_d = 1'b0;
      end else begin
         stale_d = stale_d;
      end
   end

   // Sticky timeout flag: a new timeout takes priority over a clear.
   always_comb begin
      if (timeout_set_s) begin
         timeout_d = 1'b1;
      end else if (timeout_clr_i) begin
         timeout_d = 1'b0;
      end else begin
         timeout_d = timeout_q;
      end
   end

   // State and payload registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= ST_IDLE;
         ptr_q      <= {SRC_BITS{1'b0}};
         owner_q    <= {SRC_BITS{1'b0}};
         dm_req_q   <= DMI_REQ_ZERO;
         src_resp_q <= DMI_RESP_ZERO;
         cnt_q      <= {CNT_W{1'b0}};
         stale_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         dm_req_q   <= dm_req_d;
         src_resp_q <= src_resp_d;
         cnt_q      <= cnt_d;
         stale_q    <= stale_d;
         timeout_q  <= timeout_d;
      end
   end

   // Route the response valid to the owning source only.
   always_comb begin
      src_resp_valid_o = {NUM_SRC{1'b0}};
      if (state_q == ST_RESP) begin
         src_resp_valid_o[owner_q] = 1'b1;
      end else begin
         src_resp_valid_o = {NUM_SRC{1'b0}};
      end
   end

   assign dm_req_valid_o  = (state_q == ST_ISSUE) && !stale_q;
   assign dm_resp_ready_o = (state_q == ST_WAIT) || stale_q;
   assign busy_o          = (state_q != ST_IDLE);
   assign owner_o         = owner_q;
   assign dm_req_o        = dm_req_q;
   assign src_resp_o      = src_resp_q;
   assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_riscv_dmi_arbiter.sv
// Directed bench for riscv_dmi_arbiter with three sources and a 16-cycle timeout.
module tb_riscv_dmi_arbiter;
   import riscv_dm_pkg::*;

   logic       clk = 1'b0;
   logic       rstn;
   logic [2:0] src_req_valid, src_req_ready, src_resp_valid, src_resp_ready;
   dmi_req_t   src_req [3];
   dmi_resp_t  src_resp;
   logic       dm_req_valid, dm_req_ready, dm_resp_valid, dm_resp_ready;
   dmi_req_t   dm_req;
   dmi_resp_t  dm_resp;
   logic       busy, timeout, timeout_clr;
   logic [1:0] owner;

   int checks   = 0;
   int failures = 0;

   dmi_req_t  er;
   dmi_resp_t es;
   logic [2:0] exp_oh;
   logic [1:0] exp_idx;

   always #5 clk = ~clk;

   riscv_dmi_arbiter #(.NUM_SRC(3), .TIMEOUT_CYCLES(16)) dut (
      .clk_i            (clk),
      .rstn_i           (rstn),
      .src_req_valid_i  (src_req_valid),
      .src_req_ready_o  (src_req_ready),
      .src_req_i        (src_req),
      .src_resp_valid_o (src_resp_valid),
      .src_resp_ready_i (src_resp_ready),
      .src_resp_o       (src_resp),
      .dm_req_valid_o   (dm_req_valid),
      .dm_req_ready_i   (dm_req_ready),
      .dm_req_o         (dm_req),
      .dm_resp_valid_i  (dm_resp_valid),
      .dm_resp_ready_o  (dm_resp_ready),
      .dm_resp_i        (dm_resp),
      .busy_o           (busy),
      .owner_o          (owner),
      .timeout_o        (timeout),
      .timeout_clr_i    (timeout_clr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn           = 1'b0;
      src_req_valid  = 3'b000;
      src_resp_ready = 3'b000;
      dm_req_ready   = 1'b0;
      dm_resp_valid  = 1'b0;
      dm_resp        = DMI_RESP_ZERO;
      timeout_clr    = 1'b0;
      for (int i = 0; i < 3; i++) src_req[i] = DMI_REQ_ZERO;
      #2;
      chk("rst_busy",       64'(busy), 64'd0);
      chk("rst_dm_valid",   64'(dm_req_valid), 64'd0);
      chk("rst_dm_rready",  64'(dm_resp_ready), 64'd0);
      chk("rst_resp_valid", 64'(src_resp_valid), 64'd0);
      chk("rst_timeout",    64'(timeout), 64'd0);
      chk("rst_dm_req",     64'(dm_req), 64'd0);
      #10 rstn = 1'b1;
      tick();

      // 1: single read from src0
      src_req[0]    = {7'h11, 32'h0, DMI_OP_READ};
      src_req_valid = 3'b001;
      #1 chk("t1_ready", 64'(src_req_ready), 64'h1);
      tick();
      src_req_valid = 3'b000;
      er = {7'h11, 32'h0, 2'd1};
      chk("t1_dm_valid", 64'(dm_req_valid), 64'd1);
      chk("t1_dm_req",   64'(dm_req), 64'(er));
      chk("t1_owner",    64'(owner), 64'd0);
      dm_req_ready = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      chk("t1_dm_valid_off", 64'(dm_req_valid), 64'd0);
      chk("t1_dm_rready",    64'(dm_resp_ready), 64'd1);
      dm_resp       = {32'h00400C82, 2'd0};
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      es = {32'h00400C82, 2'd0};
      chk("t1_resp_valid", 64'(src_resp_valid), 64'h1);
      chk("t1_resp",       64'(src_resp), 64'(es));
      src_resp_ready = 3'b001;
      tick();
      src_resp_ready = 3'b000;
      chk("t1_resp_done", 64'(src_resp_valid), 64'h0);
      chk("t1_idle",      64'(busy), 64'd0);

      // 2: contention between src0 and src1 from reset
      rstn = 1'b0;
      #3 rstn = 1'b1;
      tick();
      src_req[0]     = {7'h20, 32'h0000_0100, DMI_OP_READ};
      src_req[1]     = {7'h21, 32'h0000_0200, DMI_OP_READ};
      src_req_valid  = 3'b011;
      src_resp_ready = 3'b111;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_oh  = (i % 2 == 0) ? 3'b001 : 3'b010;
         exp_idx = (i % 2 == 0) ? 2'd0 : 2'd1;
         chk("t2_grant", 64'(src_req_ready), 64'(exp_oh));
         tick();
         chk("t2_owner",   64'(owner), 64'(exp_idx));
         chk("t2_dm_addr", 64'(dm_req.addr), (i % 2 == 0) ? 64'h20 : 64'h21);
         dm_req_ready = 1'b1;
         tick();
         dm_req_ready  = 1'b0;
         dm_resp       = {32'hA0 + 32'(i), 2'd0};
         dm_resp_valid = 1'b1;
         tick();
         dm_resp_valid = 1'b0;
         chk("t2_resp_valid", 64'(src_resp_valid), 64'(exp_oh));
         chk("t2_resp_data",  64'(src_resp.data), 64'hA0 + 64'(i));
         tick();
      end
      src_req_valid  = 3'b000;
      src_resp_ready = 3'b000;

      // 3: DM request and source response backpressure
      src_req[0]    = {7'h05, 32'h1234_5678, DMI_OP_WRITE};
      src_req[1]    = {7'h06, 32'h0, DMI_OP_READ};
      src_req_valid = 3'b011;
      #1 chk("t3_grant", 64'(src_req_ready), 64'h1);
      tick();
      er = {7'h05, 32'h1234_5678, 2'd2};
      for (int i = 0; i < 5; i++) begin
         chk("t3_dm_valid_hold", 64'(dm_req_valid), 64'd1);
         chk("t3_dm_req_stable", 64'(dm_req), 64'(er));
         chk("t3_no_grant",      64'(src_req_ready), 64'h0);
         tick();
      end
      dm_req_ready = 1'b1;
      chk("t3_dm_valid_acc", 64'(dm_req_valid), 64'd1);
      tick();
      dm_req_ready  = 1'b0;
      dm_resp       = {32'hCAFE_F00D, 2'd0};
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      es = {32'hCAFE_F00D, 2'd0};
      for (int i = 0; i < 7; i++) begin
         chk("t3_resp_hold",   64'(src_resp_valid), 64'h1);
         chk("t3_resp_stable", 64'(src_resp), 64'(es));
         chk("t3_no_grant2",   64'(src_req_ready), 64'h0);
         tick();
      end
      src_resp_ready = 3'b001;
      tick();
      src_resp_ready = 3'b000;
      chk("t3_next_grant", 64'(src_req_ready), 64'h2);
      src_req_valid = 3'b000;

      // 4: timeout, stale request blocking, late response discard
      src_req[0]    = {7'h12, 32'h0, DMI_OP_READ};
      src_req_valid = 3'b001;
      #1;
      tick();
      src_req_valid = 3'b000;
      dm_req_ready  = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         chk("t4_wait_noresp", 64'(src_resp_valid), 64'h0);
         tick();
      end
      chk("t4_wait_last",  64'(src_resp_valid), 64'h0);
      chk("t4_to_pending", 64'(timeout), 64'd0);
      tick();
      es = {32'h0, 2'd2};
      chk("t4_fail_valid", 64'(src_resp_valid), 64'h1);
      chk("t4_fail_resp",  64'(src_resp), 64'(es));
      chk("t4_timeout",    64'(timeout), 64'd1);
      chk("t4_stale_rdy",  64'(dm_resp_ready), 64'd1);
      src_resp_ready = 3'b001;
      tick();
      src_resp_ready = 3'b000;
      src_req[1]    = {7'h33, 32'h0, DMI_OP_READ};
      src_req_valid = 3'b010;
      #1 chk("t4_accept_src1", 64'(src_req_ready), 64'h2);
      tick();
      src_req_valid = 3'b000;
      dm_req_ready  = 1'b1;
      chk("t4_blocked",   64'(dm_req_valid), 64'd0);
      chk("t4_owner1",    64'(owner), 64'd1);
      tick();
      chk("t4_blocked2",  64'(dm_req_valid), 64'd0);
      tick();
      chk("t4_blocked3",  64'(dm_req_valid), 64'd0);
      dm_resp       = {32'hDEAD_BEEF, 2'd0};
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      chk("t4_issued",      64'(dm_req_valid), 64'd1);
      chk("t4_issued_addr", 64'(dm_req.addr), 64'h33);
      chk("t4_discarded",   64'(src_resp_valid), 64'h0);
      chk("t4_rready_off",  64'(dm_resp_ready), 64'd0);
      tick();
      dm_req_ready  = 1'b0;
      dm_resp       = {32'h0000_0077, 2'd0};
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      chk("t4_src1_resp",  64'(src_resp_valid), 64'h2);
      chk("t4_src1_data",  64'(src_resp.data), 64'h77);
      chk("t4_sticky",     64'(timeout), 64'd1);
      src_resp_ready = 3'b010;
      tick();
      src_resp_ready = 3'b000;
      timeout_clr    = 1'b1;
      tick();
      timeout_clr = 1'b0;
      chk("t4_clr", 64'(timeout), 64'd0);

      // 5a: response in the expiry cycle wins
      src_req[0]    = {7'h13, 32'h0, DMI_OP_READ};
      src_req_valid = 3'b001;
      #1;
      tick();
      src_req_valid = 3'b000;
      dm_req_ready  = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      dm_resp       = {32'h5A5A_5A5A, 2'd0};
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      es = {32'h5A5A_5A5A, 2'd0};
      chk("t5_resp_wins", 64'(src_resp), 64'(es));
      chk("t5_no_to",     64'(timeout), 64'd0);
      chk("t5_no_stale",  64'(dm_resp_ready), 64'd0);
      src_resp_ready = 3'b001;
      tick();
      src_resp_ready = 3'b000;

      // 5b: clear and new timeout together, set wins
      src_req_valid = 3'b001;
      #1;
      tick();
      src_req_valid = 3'b000;
      dm_req_ready  = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      timeout_clr = 1'b1;
      tick();
      timeout_clr = 1'b0;
      es = {32'h0, 2'd2};
      chk("t5_set_wins", 64'(timeout), 64'd1);
      chk("t5_fail",     64'(src_resp), 64'(es));
      src_resp_ready = 3'b001;
      tick();
      src_resp_ready = 3'b000;

      // 6: reset during WAIT
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      chk("t6_stale_gone", 64'(dm_resp_ready), 64'd0);
      src_req[1]    = {7'h40, 32'h0000_1111, DMI_OP_WRITE};
      src_req_valid = 3'b010;
      #1;
      tick();
      src_req_valid = 3'b000;
      dm_req_ready  = 1'b1;
      tick();
      dm_req_ready = 1'b0;
      tick();
      chk("t6_in_wait", 64'(dm_resp_ready), 64'd1);
      #2 rstn = 1'b0;
      #1;
      chk("t6_busy",       64'(busy), 64'd0);
      chk("t6_owner",      64'(owner), 64'd0);
      chk("t6_dm_rready",  64'(dm_resp_ready), 64'd0);
      chk("t6_dm_req",     64'(dm_req), 64'd0);
      chk("t6_timeout",    64'(timeout), 64'd0);
      chk("t6_src_resp",   64'(src_resp), 64'd0);
      chk("t6_resp_valid", 64'(src_resp_valid), 64'h0);
      @(posedge clk);
      #2 rstn = 1'b1;
      dm_resp       = {32'h0BAD_0BAD, 2'd0};
      dm_resp_valid = 1'b1;
      #1 chk("t6_late_rready", 64'(dm_resp_ready), 64'd0);
      tick();
      dm_resp_valid = 1'b0;
      chk("t6_late_dropped", 64'(src_resp_valid), 64'h0);
      chk("t6_late_idle",    64'(busy), 64'd0);
      src_req[2]    = {7'h2A, 32'h0000_0042, DMI_OP_NOP};
      src_req_valid = 3'b111;
      #1 chk("t6_ptr_zero", 64'(src_req_ready), 64'h1);
      src_req_valid = 3'b100;
      #1 chk("t6_grant2", 64'(src_req_ready), 64'h4);
      tick();
      src_req_valid = 3'b000;
      er = {7'h2A, 32'h0000_0042, 2'd0};
      chk("t6_owner2",  64'(owner), 64'd2);
      chk("t6_dm_req2", 64'(dm_req), 64'(er));
      dm_req_ready = 1'b1;
      tick();
      dm_req_ready  = 1'b0;
      dm_resp       = {32'h0000_0099, 2'd0};
      dm_resp_valid = 1'b1;
      tick();
      dm_resp_valid = 1'b0;
      chk("t6_resp_valid2", 64'(src_resp_valid), 64'h4);
      chk("t6_resp_data2",  64'(src_resp.data), 64'h99);
      src_resp_ready = 3'b100;
      tick();
      src_resp_ready = 3'b000;
      chk("t6_done", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
